// File: rtl/m_dmem_responder.sv
// -----------------------------------------------------------------------------
// m_dmem_responder
//
// Memory-side end of a load/store request/response handshake. One request is
// accepted at a time and held for LATENCY cycles. The access then commits:
// stores write the strobed byte lanes, and loads sample the addressed word.
// The response (read data + error flag) is held until the requester takes it.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words (word index = addr[DEPTH_LOG2+1:2])
//   LATENCY    : cycles from request acceptance to response valid (1..15)
//
// Ports
//   w_clk         in   clock, rising edge
//   w_rst_n       in   asynchronous active-low reset
//   w_req_valid   in   request present
//   w_req_ready   out  responder can accept a request (high only in IDLE)
//   w_req_addr    in   byte address
//   w_req_we      in   1 = store, 0 = load
//   w_req_wstrb   in   store byte enables, bit i -> wdata[8i+7:8i]
//   w_req_wdata   in   store data
//   w_resp_valid  out  response available (high only in RESP)
//   w_resp_ready  in   requester accepts the response
//   w_resp_rdata  out  load data; 0 for stores and errors
//   w_resp_err    out  misaligned or out-of-range request
// -----------------------------------------------------------------------------
module m_dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_req_valid,
  output logic        w_req_ready,
  input  logic [31:0] w_req_addr,
  input  logic        w_req_we,
  input  logic [3:0]  w_req_wstrb,
  input  logic [31:0] w_req_wdata,
  output logic        w_resp_valid,
  input  logic        w_resp_ready,
  output logic [31:0] w_resp_rdata,
  output logic        w_resp_err
);

  localparam int         DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  // Latched request (captured only on the accept edge)
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic [31:0] r_rdata;
  logic        r_err;

  // Storage is deliberately not reset: contents survive w_rst_n.
  logic [31:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_err;
  logic                  w_do_store;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_idx = r_addr[DEPTH_LOG2+1:2];

  // Any set bit above the word index means the address lies past the array.
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[31:DEPTH_LOG2+2] != '0);

  // The access happens on the last BUSY edge; every LATENCY (including 1)
  // passes through BUSY so that accept at edge k gives a response at k+LATENCY.
  // Gating with w_rst_n keeps a store from landing when reset coincides with the edge.
  assign w_commit   = (r_state == S_BUSY) && (r_cnt == 4'd0) && w_rst_n;
  assign w_do_store = w_commit && r_we && !w_err;
  assign w_accept   = w_req_valid && w_req_ready;

  // Output decode and next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (w_req_valid) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = LAT_M1;
        end
      end
      S_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (w_resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request capture: later changes on the request inputs are ignored.
  always_ff @(posedge w_clk) begin
    if (w_accept) begin
      r_addr  <= w_req_addr;
      r_we    <= w_req_we;
      r_wstrb <= w_req_wstrb;
      r_wdata <= w_req_wdata;
    end
  end

  // Response registers, frozen between commit and the next commit
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  assign w_resp_rdata = r_rdata;
  assign w_resp_err   = r_err;

endmodule
